// File: rtl/rf_port_scheduler_if.sv
// Bundle of handshake and register-file signals around rf_port_scheduler.
//   rd_req_*      : operand-read request from decode (rs1/rs2), ready back
//   rd_resp_valid : register-file out1/out2 valid this cycle
//   wb0_*, wb1_*  : write-back requests (ALU, load unit), ready back
//   rf_*          : drive the register file's single shared port
// modport slave  : the scheduler's view
// modport master : requesters plus register file
interface rf_port_scheduler_if;
    logic        rd_req_valid;
    logic [4:0]  rd_req_rs1;
    logic [4:0]  rd_req_rs2;
    logic        rd_req_ready;
    logic        rd_resp_valid;
    logic        wb0_valid;
    logic [4:0]  wb0_rd;
    logic [31:0] wb0_data;
    logic        wb0_ready;
    logic        wb1_valid;
    logic [4:0]  wb1_rd;
    logic [31:0] wb1_data;
    logic        wb1_ready;
    logic        rf_reg_write;
    logic [4:0]  rf_rd;
    logic [31:0] rf_write_data;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;

    modport slave (
        input  rd_req_valid, rd_req_rs1, rd_req_rs2,
        output rd_req_ready, rd_resp_valid,
        input  wb0_valid, wb0_rd, wb0_data,
        output wb0_ready,
        input  wb1_valid, wb1_rd, wb1_data,
        output wb1_ready,
        output rf_reg_write, rf_rd, rf_write_data, rf_rs1, rf_rs2
    );

    modport master (
        output rd_req_valid, rd_req_rs1, rd_req_rs2,
        input  rd_req_ready, rd_resp_valid,
        output wb0_valid, wb0_rd, wb0_data,
        input  wb0_ready,
        output wb1_valid, wb1_rd, wb1_data,
        input  wb1_ready,
        input  rf_reg_write, rf_rd, rf_write_data, rf_rs1, rf_rs2
    );
endinterface

// File: rtl/rf_port_scheduler.sv
// Time-multiplexes the single register-file port between one operand read
// (decode) and two write-back requesters (wb0 = ALU, wb1 = load unit).
// Each cycle is a write grant, a read grant or idle. Writes win when there is
// no read, when the read depends on a pending write (RAW hazard), or when a
// pending write has lost STARVE_LIMIT reads in a row. Writers round-robin.
// Ports:
//   clk  : system clock, posedge
//   rst  : synchronous active-high reset
//   bus  : rf_port_scheduler_if.slave (requests, readies, register-file drive)
module rf_port_scheduler #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_port_scheduler_if.slave   bus
);

    typedef enum logic {
        WR0 = 1'b0,
        WR1 = 1'b1
    } wr_sel_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    wr_sel_t          last_wr_q;
    logic             rd_resp_q;

    logic pend0, pend1, any_pend, hazard, starved;
    logic wr_grant, rd_grant, pick1;

    always_comb begin
        // rd==0 requests are absorbed separately and never count as pending
        pend0    = bus.wb0_valid && (bus.wb0_rd != '0);
        pend1    = bus.wb1_valid && (bus.wb1_rd != '0);
        any_pend = pend0 || pend1;
        hazard   = bus.rd_req_valid &&
                   ((pend0 && (bus.wb0_rd == bus.rd_req_rs1 || bus.wb0_rd == bus.rd_req_rs2)) ||
                    (pend1 && (bus.wb1_rd == bus.rd_req_rs1 || bus.wb1_rd == bus.rd_req_rs2)));
        starved  = (starve_cnt_q >= LIMIT);
        wr_grant = !rst && any_pend && (!bus.rd_req_valid || hazard || starved);
        rd_grant = !rst && bus.rd_req_valid && !wr_grant;
        // on a tie, the writer not served last goes
        pick1    = pend1 && (!pend0 || last_wr_q == WR0);

        bus.rd_req_ready  = rd_grant;
        bus.wb0_ready     = !rst && ((bus.wb0_valid && bus.wb0_rd == '0) || (wr_grant && !pick1));
        bus.wb1_ready     = !rst && ((bus.wb1_valid && bus.wb1_rd == '0) || (wr_grant && pick1));
        bus.rf_reg_write  = wr_grant;
        bus.rf_rd         = '0;
        bus.rf_write_data = '0;
        if (wr_grant) begin
            bus.rf_rd         = pick1 ? bus.wb1_rd   : bus.wb0_rd;
            bus.rf_write_data = pick1 ? bus.wb1_data : bus.wb0_data;
        end
        bus.rf_rs1        = bus.rd_req_rs1;
        bus.rf_rs2        = bus.rd_req_rs2;
        bus.rd_resp_valid = rd_resp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_resp_q    <= 1'b0;
            starve_cnt_q <= '0;
            last_wr_q    <= WR1;
        end else begin
            rd_resp_q <= rd_grant;
            if (wr_grant || !any_pend) begin
                starve_cnt_q <= '0;
            end else if (rd_grant && starve_cnt_q != '1) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end
            if (wr_grant) begin
                last_wr_q <= pick1 ? WR1 : WR0;
            end
        end
    end

endmodule

// File: tb/tb_rf_port_scheduler.sv
module tb_rf_port_scheduler;

    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = 3;
    localparam int SAT          = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    rf_port_scheduler_if bus();

    rf_port_scheduler #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: which writer was served last (0/1), how many reads
    // in a row a pending write has lost, and whether a read was granted.
    int m_last   = 1;
    int m_starve = 0;
    bit m_resp   = 1'b0;

    // Decision for the current inputs: 0 idle, 1 read, 2 wb0 write, 3 wb1 write
    function automatic int decide();
        bit p0, p1, hz;
        p0 = bus.wb0_valid && bus.wb0_rd != 0;
        p1 = bus.wb1_valid && bus.wb1_rd != 0;
        if (rst) return 0;
        if (p0 || p1) begin
            hz = bus.rd_req_valid &&
                 ((p0 && (bus.wb0_rd == bus.rd_req_rs1 || bus.wb0_rd == bus.rd_req_rs2)) ||
                  (p1 && (bus.wb1_rd == bus.rd_req_rs1 || bus.wb1_rd == bus.rd_req_rs2)));
            if (!bus.rd_req_valid || hz || m_starve >= STARVE_LIMIT) begin
                if (p0 && p1) return (m_last == 0) ? 3 : 2;
                return p0 ? 2 : 3;
            end
        end
        if (bus.rd_req_valid) return 1;
        return 0;
    endfunction

    // Advance one clock: update the reference at the edge, return at negedge.
    task automatic tick();
        int g;
        bit any;
        g   = decide();
        any = (bus.wb0_valid && bus.wb0_rd != 0) || (bus.wb1_valid && bus.wb1_rd != 0);
        @(posedge clk);
        if (rst) begin
            m_resp = 1'b0; m_starve = 0; m_last = 1;
        end else begin
            m_resp = (g == 1);
            if (g >= 2) m_last = g - 2;
            if (g >= 2 || !any) m_starve = 0;
            else if (g == 1 && m_starve < SAT) m_starve++;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.rd_req_valid = 0; bus.rd_req_rs1 = 0; bus.rd_req_rs2 = 0;
        bus.wb0_valid = 0; bus.wb0_rd = 0; bus.wb0_data = 0;
        bus.wb1_valid = 0; bus.wb1_rd = 0; bus.wb1_data = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        bus.wb0_valid = 1; bus.wb0_rd = 5; bus.wb0_data = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.wb0_ready !== 1'b0 || bus.wb1_ready !== 1'b0 || bus.rd_req_ready !== 1'b0 ||
                bus.rf_reg_write !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_write_data !== 32'd0) begin
                errors++;
                $display("FAIL reset_outputs: got w0r=%b w1r=%b rr=%b we=%b rd=%0d data=%h, want all 0",
                         bus.wb0_ready, bus.wb1_ready, bus.rd_req_ready, bus.rf_reg_write,
                         bus.rf_rd, bus.rf_write_data);
            end
            tick();
        end
        checks++;
        if (bus.rd_resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_resp: got %b want 0", bus.rd_resp_valid);
        end
        rst = 0;
        #1;
        checks++;
        if (bus.wb0_ready !== 1'b1 || bus.rf_reg_write !== 1'b1 || bus.rf_rd !== 5'd5 ||
            bus.rf_write_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL first_write: got w0r=%b we=%b rd=%0d data=%h want 1 1 5 deadbeef",
                     bus.wb0_ready, bus.rf_reg_write, bus.rf_rd, bus.rf_write_data);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.rd_resp_valid !== 1'b0) begin
            errors++; $display("FAIL write_no_resp: got %b want 0", bus.rd_resp_valid);
        end
    endtask

    task automatic test_read_latency();
        idle_inputs();
        bus.rd_req_valid = 1; bus.rd_req_rs1 = 5; bus.rd_req_rs2 = 0;
        #1;
        checks++;
        if (bus.rd_req_ready !== 1'b1 || bus.rf_reg_write !== 1'b0 || bus.rf_rs1 !== 5'd5 ||
            bus.rf_rs2 !== 5'd0 || bus.rd_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_grant: got rr=%b we=%b rs1=%0d rs2=%0d resp=%b want 1 0 5 0 0",
                     bus.rd_req_ready, bus.rf_reg_write, bus.rf_rs1, bus.rf_rs2, bus.rd_resp_valid);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.rd_resp_valid !== 1'b1) begin
            errors++; $display("FAIL read_resp_n1: got %b want 1", bus.rd_resp_valid);
        end
        tick();
        checks++;
        if (bus.rd_resp_valid !== 1'b0) begin
            errors++; $display("FAIL read_resp_n2: got %b want 0", bus.rd_resp_valid);
        end
    endtask

    task automatic test_raw_hazard();
        idle_inputs();
        bus.rd_req_valid = 1; bus.rd_req_rs1 = 7; bus.rd_req_rs2 = 2;
        bus.wb1_valid = 1; bus.wb1_rd = 7; bus.wb1_data = 32'h0000_1234;
        #1;
        checks++;
        if (bus.wb1_ready !== 1'b1 || bus.rd_req_ready !== 1'b0 || bus.rf_rd !== 5'd7 ||
            bus.rf_write_data !== 32'h1234) begin
            errors++;
            $display("FAIL raw_write_first: got w1r=%b rr=%b rd=%0d data=%h want 1 0 7 00001234",
                     bus.wb1_ready, bus.rd_req_ready, bus.rf_rd, bus.rf_write_data);
        end
        tick();
        bus.wb1_valid = 0;
        #1;
        checks++;
        if (bus.rd_req_ready !== 1'b1 || bus.rf_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL raw_read_next: got rr=%b we=%b want 1 0", bus.rd_req_ready, bus.rf_reg_write);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.rd_resp_valid !== 1'b1) begin
            errors++; $display("FAIL raw_resp: got %b want 1", bus.rd_resp_valid);
        end
    endtask

    task automatic test_round_robin();
        // last writer was wb1 (hazard test), so wb0 leads
        idle_inputs();
        bus.wb0_valid = 1; bus.wb0_rd = 3; bus.wb0_data = 32'h3333;
        bus.wb1_valid = 1; bus.wb1_rd = 4; bus.wb1_data = 32'h4444;
        for (int i = 0; i < 4; i++) begin
            logic [4:0] want_rd;
            want_rd = (i % 2 == 0) ? 5'd3 : 5'd4;
            #1;
            checks++;
            if (bus.rf_rd !== want_rd || bus.wb0_ready !== (want_rd == 5'd3) ||
                bus.wb1_ready !== (want_rd == 5'd4) || bus.rf_reg_write !== 1'b1) begin
                errors++;
                $display("FAIL round_robin[%0d]: got rd=%0d w0r=%b w1r=%b we=%b want rd=%0d",
                         i, bus.rf_rd, bus.wb0_ready, bus.wb1_ready, bus.rf_reg_write, want_rd);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        idle_inputs();
        bus.rd_req_valid = 1; bus.rd_req_rs1 = 1; bus.rd_req_rs2 = 2;
        bus.wb0_valid = 1; bus.wb0_rd = 9; bus.wb0_data = 32'h9999;
        // two rounds: the second proves the counter restarted after the write
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i <= STARVE_LIMIT; i++) begin
                bit want_w;
                want_w = (i == STARVE_LIMIT);
                #1;
                checks++;
                if (bus.wb0_ready !== want_w || bus.rd_req_ready !== !want_w ||
                    bus.rf_reg_write !== want_w) begin
                    errors++;
                    $display("FAIL starve[%0d.%0d]: got w0r=%b rr=%b we=%b want w0r=%b",
                             r, i, bus.wb0_ready, bus.rd_req_ready, bus.rf_reg_write, want_w);
                end
                tick();
            end
        end
        idle_inputs();
    endtask

    task automatic test_x0_and_reset();
        idle_inputs();
        bus.rd_req_valid = 1; bus.rd_req_rs1 = 3; bus.rd_req_rs2 = 0;
        bus.wb1_valid = 1; bus.wb1_rd = 0; bus.wb1_data = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (bus.wb1_ready !== 1'b1 || bus.rf_reg_write !== 1'b0 || bus.rd_req_ready !== 1'b1 ||
            bus.rf_write_data !== 32'd0) begin
            errors++;
            $display("FAIL x0_write: got w1r=%b we=%b rr=%b data=%h want 1 0 1 0",
                     bus.wb1_ready, bus.rf_reg_write, bus.rd_req_ready, bus.rf_write_data);
        end
        tick();
        idle_inputs();
        rst = 1;
        bus.wb0_valid = 1; bus.wb0_rd = 6; bus.wb0_data = 32'h6666;
        #1;
        checks++;
        if (bus.wb0_ready !== 1'b0 || bus.wb1_ready !== 1'b0 || bus.rd_req_ready !== 1'b0 ||
            bus.rf_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got w0r=%b w1r=%b rr=%b we=%b want 0",
                     bus.wb0_ready, bus.wb1_ready, bus.rd_req_ready, bus.rf_reg_write);
        end
        tick();
        rst = 0;
        #1;
        checks++;
        if (bus.wb0_ready !== 1'b1 || bus.rf_rd !== 5'd6 || bus.rf_write_data !== 32'h6666) begin
            errors++;
            $display("FAIL after_reset_serve: got w0r=%b rd=%0d data=%h want 1 6 00006666",
                     bus.wb0_ready, bus.rf_rd, bus.rf_write_data);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            int g;
            bit e_rr, e_w0, e_w1;
            logic [4:0]  e_rd;
            logic [31:0] e_data;
            rst = ($urandom_range(0, 39) == 0);
            // requesters hold valid and payload until their ready is seen
            if (!bus.wb0_valid && $urandom_range(0, 2) != 0) begin
                bus.wb0_valid = 1; bus.wb0_rd = 5'($urandom_range(0, 7)); bus.wb0_data = $urandom;
            end
            if (!bus.wb1_valid && $urandom_range(0, 2) != 0) begin
                bus.wb1_valid = 1; bus.wb1_rd = 5'($urandom_range(0, 7)); bus.wb1_data = $urandom;
            end
            if (!bus.rd_req_valid && $urandom_range(0, 3) != 0) begin
                bus.rd_req_valid = 1;
                bus.rd_req_rs1 = 5'($urandom_range(0, 7));
                bus.rd_req_rs2 = 5'($urandom_range(0, 7));
            end
            #1;
            g      = decide();
            e_rr   = (g == 1);
            e_w0   = !rst && (g == 2 || (bus.wb0_valid && bus.wb0_rd == 0));
            e_w1   = !rst && (g == 3 || (bus.wb1_valid && bus.wb1_rd == 0));
            e_rd   = (g == 2) ? bus.wb0_rd   : (g == 3) ? bus.wb1_rd   : 5'd0;
            e_data = (g == 2) ? bus.wb0_data : (g == 3) ? bus.wb1_data : 32'd0;
            checks++;
            if (bus.rd_req_ready !== e_rr || bus.wb0_ready !== e_w0 || bus.wb1_ready !== e_w1) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got rr=%b w0r=%b w1r=%b want %b %b %b",
                         n, bus.rd_req_ready, bus.wb0_ready, bus.wb1_ready, e_rr, e_w0, e_w1);
            end
            checks++;
            if (bus.rf_reg_write !== (g >= 2) || bus.rf_rd !== e_rd || bus.rf_write_data !== e_data) begin
                errors++;
                $display("FAIL rand_rf[%0d]: got we=%b rd=%0d data=%h want %b %0d %h",
                         n, bus.rf_reg_write, bus.rf_rd, bus.rf_write_data, (g >= 2), e_rd, e_data);
            end
            checks++;
            if (bus.rd_resp_valid !== m_resp || bus.rf_rs1 !== bus.rd_req_rs1 ||
                bus.rf_rs2 !== bus.rd_req_rs2) begin
                errors++;
                $display("FAIL rand_resp[%0d]: got resp=%b rs1=%0d rs2=%0d want %b %0d %0d",
                         n, bus.rd_resp_valid, bus.rf_rs1, bus.rf_rs2, m_resp,
                         bus.rd_req_rs1, bus.rd_req_rs2);
            end
            tick();
            if (e_w0) bus.wb0_valid = 0;
            if (e_w1) bus.wb1_valid = 0;
            if (e_rr) bus.rd_req_valid = 0;
        end
        rst = 0;
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_read_latency();
        test_raw_hazard();
        test_round_robin();
        test_starvation();
        test_x0_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
